// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between IF and decode
//
// Purpose:
//   Buffers {pc, inst} pairs from the IF stage in a small in-order FIFO.
//   The head entry is presented to decode with a valid/ready handshake.
//   pc_stall holds the IF PC while the queue is full. br_ctrl discards
//   every buffered entry.
//
// Ports:
//   clk          in   1          clock, rising edge
//   rst          in   1          asynchronous active-low reset
//   fetch_valid  in   1          IF pair valid this cycle
//   if_pc        in   32         PC of fetched instruction
//   if_inst      in   32         fetched instruction word
//   br_ctrl      in   1          redirect/flush, has priority over push and pop
//   pc_stall     out  1          hold IF PC, high when the queue is full
//   id_ready     in   1          decode accepts the head entry
//   id_valid     out  1          head entry valid
//   id_pc        out  32         head PC, 0 when empty
//   id_inst      out  32         head instruction, NOP_INST when empty
//   count        out  AW+1       occupancy 0..DEPTH

module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_inst,
  input  logic                     br_ctrl,
  output logic                     pc_stall,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Full comes from registered occupancy only, so pc_stall has no
  // combinational path from id_ready or the IF inputs. A pop while full
  // therefore cannot make room for a push in the same cycle.
  assign full     = (count_q == CW'(DEPTH));
  assign id_valid = (count_q != '0);
  assign push     = fetch_valid & ~full & ~br_ctrl;
  assign pop      = id_valid & id_ready & ~br_ctrl;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (br_ctrl) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {if_pc, if_inst};
  end

  // First-word-fall-through from registered state, no write bypass
  assign head     = mem_q[rd_ptr_q];
  assign id_pc    = id_valid ? head[63:32] : 32'h0;
  assign id_inst  = id_valid ? head[31:0]  : NOP_INST;
  assign pc_stall = full;
  assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        br_ctrl;
  logic        pc_stall;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(4), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .br_ctrl     (br_ctrl),
    .pc_stall    (pc_stall),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc);
    fetch_valid = 1'b1;
    if_pc       = pc;
    if_inst     = 32'hA000_0000 | pc;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", id_valid); end
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", pc_stall); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", id_pc); end
    checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", id_inst, NOP); end
    rst = 1'b1;
    tick();
    present(32'h100);
    tick();
    fetch_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL prereset_count got %0d exp 1", count); end
    checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL prereset_pc got %h exp 100", id_pc); end
    // assert reset mid-cycle, away from any clock edge
    #2 rst = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %0b exp 0", id_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_reset_count got %0d exp 0", count); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc got %h exp 0", id_pc); end
    checks++; if (id_inst !== NOP) begin errors++; $display("FAIL async_reset_inst got %h exp %h", id_inst, NOP); end
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL async_reset_stall got %0b exp 0", pc_stall); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(pcs[i]);
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++; if (pc_stall !== (i == 3)) begin errors++; $display("FAIL fill_stall[%0d] got %0b exp %0b", i, pc_stall, (i == 3)); end
    end
    present(32'h10);
    tick();
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_held_count got %0d exp 4", count); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL fill_head_pc got %h exp 0", id_pc); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL fill_held_stall got %0b exp 1", pc_stall); end
  endtask

  task automatic test_drain();
    logic [31:0] exp_pc;
    fetch_valid = 1'b0;
    id_ready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(4 * i);
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %0b exp 1", i, id_valid); end
      checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL drain_pc[%0d] got %h exp %h", i, id_pc, exp_pc); end
      checks++; if (id_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL drain_inst[%0d] got %h exp %h", i, id_inst, 32'hA000_0000 | exp_pc); end
      tick();
    end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %0b exp 0", id_valid); end
    checks++; if (id_inst !== NOP) begin errors++; $display("FAIL drain_empty_inst got %h exp %h", id_inst, NOP); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_empty_count got %0d exp 0", count); end
    id_ready = 1'b0;
  endtask

  task automatic test_concurrent();
    logic [31:0] exp_pc;
    present(32'h200);
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid got %0b exp 0", id_valid); end
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL push_empty_valid got %0b exp 1", id_valid); end
    checks++; if (id_pc !== 32'h200) begin errors++; $display("FAIL push_empty_pc got %h exp 200", id_pc); end
    present(32'h204);
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL conc_start_count got %0d exp 2", count); end
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      present(32'h208 + 32'(4 * k));
      exp_pc = 32'h200 + 32'(4 * k);
      checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL conc_pc[%0d] got %h exp %h", k, id_pc, exp_pc); end
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL conc_count[%0d] got %0d exp 2", k, count); end
    end
    fetch_valid = 1'b0;
    id_ready    = 1'b0;
    checks++; if (id_pc !== 32'h220) begin errors++; $display("FAIL conc_end_pc got %h exp 220", id_pc); end
  endtask

  task automatic test_flush();
    present(32'h300);
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    present(32'h304);
    id_ready = 1'b1;
    br_ctrl  = 1'b1;
    tick();
    br_ctrl  = 1'b0;
    id_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", id_valid); end
    checks++; if (id_inst !== NOP) begin errors++; $display("FAIL flush_inst got %h exp %h", id_inst, NOP); end
    present(32'h80);
    tick();
    checks++; if (id_pc !== 32'h80) begin errors++; $display("FAIL flush_next_pc got %h exp 80", id_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_next_count got %0d exp 1", count); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc;
    for (int i = 1; i < 4; i++) begin
      present(32'h80 + 32'(4 * i));
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_pre_count got %0d exp 4", count); end
    present(32'h90);
    id_ready = 1'b1;
    #1;
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL fullpop_stall_same got %0b exp 1", pc_stall); end
    tick();
    id_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d exp 3", count); end
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fullpop_stall_next got %0b exp 0", pc_stall); end
    checks++; if (id_pc !== 32'h84) begin errors++; $display("FAIL fullpop_head got %h exp 84", id_pc); end
    tick();
    fetch_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL heldpush_count got %0d exp 4", count); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL heldpush_stall got %0b exp 1", pc_stall); end
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h84 + 32'(4 * i);
      checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL fullpop_order[%0d] got %h exp %h", i, id_pc, exp_pc); end
      tick();
    end
    id_ready = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %0b exp 0", id_valid); end
  endtask

  initial begin
    rst         = 1'b0;
    fetch_valid = 1'b0;
    if_pc       = 32'h0;
    if_inst     = 32'h0;
    br_ctrl     = 1'b0;
    id_ready    = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_flush();
    test_full_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
